// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request in
// flight, buffers one instruction for decode and squashes wrong-path responses.
module ifu_fetch_stage #(
  parameter int unsigned           ADDR_W   = 64,
  parameter int unsigned           INS_W    = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INS_W-1:0]  imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INS_W-1:0]  out_ins
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_drop;
  logic                r_out_valid;
  logic [ADDR_W-1:0]   r_out_pc;
  logic [INS_W-1:0]    r_out_ins;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                w_drop_nxt;
  logic                w_out_valid_nxt;
  logic [ADDR_W-1:0]   w_out_pc_nxt;
  logic [INS_W-1:0]    w_out_ins_nxt;
  logic [ADDR_W-1:0]   w_redirect_pc;

  assign w_redirect_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_req_valid = (r_state == S_REQ) && !reset;
  assign imem_req_addr  = r_pc;
  assign out_valid      = r_out_valid;
  assign out_pc         = r_out_pc;
  assign out_ins        = r_out_ins;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_ins   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop      <= w_drop_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_ins   <= w_out_ins_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_nxt      = r_drop;
    w_out_valid_nxt = r_out_valid;
    w_out_pc_nxt    = r_out_pc;
    w_out_ins_nxt   = r_out_ins;

    case (r_state)
      S_REQ: begin
        // An accepted request still goes out on a redirect; its answer is squashed.
        if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
          if (redirect_valid) w_drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (r_drop || redirect_valid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_out_ins_nxt   = imem_rsp_data;
            w_out_pc_nxt    = r_pc;
            w_out_valid_nxt = 1'b1;
            w_pc_nxt        = r_pc + ADDR_W'(4);
            w_state_nxt     = S_FULL;
          end
        end else if (redirect_valid) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect_valid || out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase

    // Redirect overrides the pc update and kills any buffered instruction.
    if (redirect_valid) begin
      w_pc_nxt        = w_redirect_pc;
      w_out_valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Self-checking bench for ifu_fetch_stage: scoreboard of fetched {pc, ins}
// pairs, scenario tasks for handshake, stall, redirect, wrap and reset.
module tb_ifu_fetch_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_ins;

  int    total = 0;
  int    bad = 0;
  item_t sb[$];

  ifu_fetch_stage #(
    .ADDR_W  (64),
    .INS_W   (32),
    .RESET_PC(64'h8000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_ins       (out_ins)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept the current request; memory answers on the following cycle.
  task automatic fetch(input logic [31:0] data, input bit keep);
    item_t e;
    e.pc  = imem_req_addr;
    e.ins = data;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    if (keep) sb.push_back(e);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  task automatic pop_exp(output item_t e);
    if (sb.size() == 0) e = '0;
    else e = sb.pop_front();
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b want=0", imem_req_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL rst_out_pc got=%h want=0", out_pc); end
    total++; if (out_ins !== 32'h0) begin bad++; $display("FAIL rst_out_ins got=%h want=0", out_ins); end
    reset = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%b want=1", imem_req_valid); end
    total++; if (imem_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL first_req_addr got=%h want=80000000", imem_req_addr); end
  endtask

  task automatic test_basic();
    item_t e;
    fetch(32'h0000_0013, 1'b1);
    pop_exp(e);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
    total++; if (out_pc !== 64'h8000_0000) begin bad++; $display("FAIL basic_out_pc got=%h want=80000000", out_pc); end
    total++; if (out_ins !== e.ins) begin bad++; $display("FAIL basic_out_ins got=%h want=%h", out_ins, e.ins); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL basic_full_req got=%b want=0", imem_req_valid); end
    handshake();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop_valid got=%b want=0", out_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004)
      begin bad++; $display("FAIL basic_next_req got=%b/%h want=1/80000004", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stall();
    item_t e;
    fetch(32'h0010_0093, 1'b1);
    pop_exp(e);
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_ins !== e.ins || imem_req_valid !== 1'b0)
        begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%b want=1/%h/%h/0", i, out_valid, out_pc, out_ins, imem_req_valid, e.pc, e.ins); end
      tick();
    end
    handshake();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", out_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008)
      begin bad++; $display("FAIL stall_next_req got=%b/%h want=1/80000008", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0103; tick(); redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rwait_no_req got=%b want=0", imem_req_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; tick(); imem_rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rwait_dropped got=%b want=0", out_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100)
      begin bad++; $display("FAIL rwait_next_req got=%b/%h want=1/80000100", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_rsp();
    item_t e;
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rrsp_no_valid got=%b want=0", out_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200)
      begin bad++; $display("FAIL rrsp_next_req got=%b/%h want=1/80000200", imem_req_valid, imem_req_addr); end
    fetch(32'h2222_2222, 1'b1);
    pop_exp(e);
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0200 || out_ins !== e.ins)
      begin bad++; $display("FAIL rrsp_after got=%b/%h/%h want=1/80000200/%h", out_valid, out_pc, out_ins, e.ins); end
    handshake();
    total++; if (imem_req_addr !== 64'h8000_0204) begin bad++; $display("FAIL rrsp_pc_inc got=%h want=80000204", imem_req_addr); end
  endtask

  task automatic test_redirect_full();
    fetch(32'h3333_3333, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rfull_pre got=%b want=1", out_valid); end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    tick();
    out_ready = 1'b0; redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rfull_killed got=%b want=0", out_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0300)
      begin bad++; $display("FAIL rfull_next_req got=%b/%h want=1/80000300", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_req();
    item_t e;
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rreq_wait got=%b want=0", imem_req_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4444_4444; tick(); imem_rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || imem_req_addr !== 64'h8000_0400)
      begin bad++; $display("FAIL rreq_dropped got=%b/%h want=0/80000400", out_valid, imem_req_addr); end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0502; tick(); redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0500)
      begin bad++; $display("FAIL rreq_noready got=%b/%h want=1/80000500", imem_req_valid, imem_req_addr); end
    fetch(32'h5555_5555, 1'b1);
    pop_exp(e);
    total++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_ins !== e.ins)
      begin bad++; $display("FAIL rreq_deliver got=%b/%h/%h want=1/%h/%h", out_valid, out_pc, out_ins, e.pc, e.ins); end
    handshake();
  endtask

  task automatic test_back_to_back();
    item_t e;
    for (int i = 0; i < 4; i++) begin
      fetch($urandom, 1'b1);
      pop_exp(e);
      total++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_ins !== e.ins)
        begin bad++; $display("FAIL b2b_out[%0d] got=%b/%h/%h want=1/%h/%h", i, out_valid, out_pc, out_ins, e.pc, e.ins); end
      handshake();
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== e.pc + 64'd4)
        begin bad++; $display("FAIL b2b_req[%0d] got=%b/%h want=1/%h", i, imem_req_valid, imem_req_addr, e.pc + 64'd4); end
    end
  endtask

  task automatic test_wrap();
    item_t e;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick(); redirect_valid = 1'b0;
    fetch(32'h0000_0013, 1'b1);
    pop_exp(e);
    total++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_ins !== e.ins)
      begin bad++; $display("FAIL wrap_out got=%h/%h want=fffffffffffffffc/%h", out_pc, out_ins, e.ins); end
    handshake();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0)
      begin bad++; $display("FAIL wrap_req got=%b/%h want=1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid();
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    reset = 1'b1; tick();
    total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 64'h0 || out_ins !== 32'h0)
      begin bad++; $display("FAIL midrst_state got=%b/%b/%h/%h want=0/0/0/0", imem_req_valid, out_valid, out_pc, out_ins); end
    reset = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h6666_6666;
    tick();
    imem_rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale_rsp got=%b want=0", out_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000)
      begin bad++; $display("FAIL midrst_req got=%b/%h want=1/80000000", imem_req_valid, imem_req_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_full();
    test_redirect_req();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
